// File: rtl/axi_riscv_txn_limit.sv
// axi_riscv_txn_limit
//   Upstream stage of the LR/SC adapter. Caps the number of in-flight AXI read
//   and write transactions so the adapter's ID queues cannot overflow, and
//   holds W beats until the AW they belong to has been forwarded. Payloads
//   pass through untouched; only valid/ready are gated.
//
//   Gating uses registered counts only. A completion in cycle N frees its
//   slot from cycle N+1; there is no same-cycle bypass.
//
//   MAX_READ_TXNS and MAX_WRITE_TXNS must both be at least 1.
//
//   Optional build macro AXI_RISCV_TXN_LIMIT_STATS_EN adds three saturating
//   32-bit stall counters: stall_aw_o, stall_ar_o and stall_w_o.
module axi_riscv_txn_limit #(
    parameter int unsigned AW_CHAN_W      = 64,
    parameter int unsigned AR_CHAN_W      = 64,
    parameter int unsigned W_CHAN_W       = 73,
    parameter int unsigned R_CHAN_W       = 70,
    parameter int unsigned B_CHAN_W       = 8,
    parameter int unsigned MAX_READ_TXNS  = 4,
    parameter int unsigned MAX_WRITE_TXNS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    // AW channel
    input  logic [AW_CHAN_W-1:0] slv_aw_chan_i,
    input  logic [5:0]           slv_aw_atop_i,
    input  logic                 slv_aw_valid_i,
    output logic                 slv_aw_ready_o,
    output logic [AW_CHAN_W-1:0] mst_aw_chan_o,
    output logic [5:0]           mst_aw_atop_o,
    output logic                 mst_aw_valid_o,
    input  logic                 mst_aw_ready_i,

    // AR channel
    input  logic [AR_CHAN_W-1:0] slv_ar_chan_i,
    input  logic                 slv_ar_valid_i,
    output logic                 slv_ar_ready_o,
    output logic [AR_CHAN_W-1:0] mst_ar_chan_o,
    output logic                 mst_ar_valid_o,
    input  logic                 mst_ar_ready_i,

    // W channel
    input  logic [W_CHAN_W-1:0]  slv_w_chan_i,
    input  logic                 slv_w_last_i,
    input  logic                 slv_w_valid_i,
    output logic                 slv_w_ready_o,
    output logic [W_CHAN_W-1:0]  mst_w_chan_o,
    output logic                 mst_w_last_o,
    output logic                 mst_w_valid_o,
    input  logic                 mst_w_ready_i,

    // R channel
    input  logic [R_CHAN_W-1:0]  mst_r_chan_i,
    input  logic                 mst_r_last_i,
    input  logic                 mst_r_valid_i,
    output logic                 mst_r_ready_o,
    output logic [R_CHAN_W-1:0]  slv_r_chan_o,
    output logic                 slv_r_last_o,
    output logic                 slv_r_valid_o,
    input  logic                 slv_r_ready_i,

    // B channel
    input  logic [B_CHAN_W-1:0]  mst_b_chan_i,
    input  logic                 mst_b_valid_i,
    output logic                 mst_b_ready_o,
    output logic [B_CHAN_W-1:0]  slv_b_chan_o,
    output logic                 slv_b_valid_o,
    input  logic                 slv_b_ready_i
`ifdef AXI_RISCV_TXN_LIMIT_STATS_EN
    ,
    output logic [31:0]          stall_aw_o,
    output logic [31:0]          stall_ar_o,
    output logic [31:0]          stall_w_o
`endif
);

    // Counter widths, plus two guard bits so that +2 / -1 arithmetic can be
    // range-checked before it is committed.
    localparam int unsigned RD_W = $clog2(MAX_READ_TXNS + 1);
    localparam int unsigned WR_W = $clog2(MAX_WRITE_TXNS + 1);
    localparam int unsigned RX_W = RD_W + 2;
    localparam int unsigned WX_W = WR_W + 2;

    localparam logic [RD_W-1:0] RD_MAX    = RD_W'(MAX_READ_TXNS);
    localparam logic [RD_W-1:0] RD_MAX_M1 = RD_W'(MAX_READ_TXNS - 1);
    localparam logic [WR_W-1:0] WR_MAX    = WR_W'(MAX_WRITE_TXNS);
    localparam logic [RX_W-1:0] RD_LIMIT  = RX_W'(MAX_READ_TXNS);
    localparam logic [WX_W-1:0] WR_LIMIT  = WX_W'(MAX_WRITE_TXNS);

    // Registered occupancy counters and their next-state values.
    logic [RD_W-1:0] rd_cnt_q,  rd_cnt_d;
    logic [WR_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic [WR_W-1:0] w_cred_q,  w_cred_d;

    // Gate terms.
    logic aw_has_r;     // this AW is an ATOP that also returns an R burst
    logic rd_ok;
    logic wr_ok;
    logic ar_priority;  // last read slot contested by AR and ATOP-AW
    logic aw_ok;
    logic ar_ok;
    logic w_ok;

    // Handshakes as seen on the downstream side.
    logic aw_hs;
    logic ar_hs;
    logic w_last_hs;
    logic r_last_hs;
    logic b_hs;

    // Wide intermediates and error flags for each counter.
    logic [RX_W-1:0] rd_sum, rd_next;
    logic [WX_W-1:0] wr_sum, wr_next;
    logic [WX_W-1:0] wc_sum, wc_next;
    logic            rd_under, rd_over;
    logic            wr_under, wr_over;
    logic            wc_under, wc_over;

    // Admission gates, all derived from registered counts.
    always_comb begin
        aw_has_r    = slv_aw_atop_i[5];
        rd_ok       = (rd_cnt_q < RD_MAX);
        wr_ok       = (wr_cnt_q < WR_MAX);
        // Only one read slot left: an AR and an R-returning ATOP would each
        // pass the check on their own, so the AR wins and the ATOP waits.
        ar_priority = slv_ar_valid_i && (rd_cnt_q == RD_MAX_M1);
        ar_ok       = rd_ok;
        aw_ok       = wr_ok && (!aw_has_r || (rd_ok && !ar_priority));
        w_ok        = (w_cred_q != '0);
    end

    // Payload pass-through.
    assign mst_aw_chan_o = slv_aw_chan_i;
    assign mst_aw_atop_o = slv_aw_atop_i;
    assign mst_ar_chan_o = slv_ar_chan_i;
    assign mst_w_chan_o  = slv_w_chan_i;
    assign mst_w_last_o  = slv_w_last_i;
    assign slv_r_chan_o  = mst_r_chan_i;
    assign slv_r_last_o  = mst_r_last_i;
    assign slv_b_chan_o  = mst_b_chan_i;

    // Gated handshakes. An upstream valid held while gated stays legal,
    // because downstream never sees it.
    assign mst_aw_valid_o = slv_aw_valid_i && aw_ok;
    assign slv_aw_ready_o = mst_aw_ready_i && aw_ok;
    assign mst_ar_valid_o = slv_ar_valid_i && ar_ok;
    assign slv_ar_ready_o = mst_ar_ready_i && ar_ok;
    assign mst_w_valid_o  = slv_w_valid_i  && w_ok;
    assign slv_w_ready_o  = mst_w_ready_i  && w_ok;

    // Ungated response channels.
    assign slv_r_valid_o = mst_r_valid_i;
    assign mst_r_ready_o = slv_r_ready_i;
    assign slv_b_valid_o = mst_b_valid_i;
    assign mst_b_ready_o = slv_b_ready_i;

    assign aw_hs     = slv_aw_valid_i && mst_aw_ready_i && aw_ok;
    assign ar_hs     = slv_ar_valid_i && mst_ar_ready_i && ar_ok;
    assign w_last_hs = slv_w_valid_i  && mst_w_ready_i  && w_ok && slv_w_last_i;
    assign r_last_hs = mst_r_valid_i  && slv_r_ready_i  && mst_r_last_i;
    assign b_hs      = mst_b_valid_i  && slv_b_ready_i;

    // Next-state counter arithmetic. On underflow or saturation the counter
    // holds its value and the error checks below report it.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // so no latch is inferred.
        rd_sum   = {2'b00, rd_cnt_q} + RX_W'(ar_hs) + RX_W'(aw_hs && aw_has_r);
        rd_under = r_last_hs && (rd_sum == '0);
        rd_next  = rd_sum - RX_W'(r_last_hs);
        rd_over  = !rd_under && (rd_next > RD_LIMIT);
        rd_cnt_d = (rd_under || rd_over) ? rd_cnt_q : rd_next[RD_W-1:0];

        wr_sum   = {2'b00, wr_cnt_q} + WX_W'(aw_hs);
        wr_under = b_hs && (wr_sum == '0);
        wr_next  = wr_sum - WX_W'(b_hs);
        wr_over  = !wr_under && (wr_next > WR_LIMIT);
        wr_cnt_d = (wr_under || wr_over) ? wr_cnt_q : wr_next[WR_W-1:0];

        // Simultaneous AW and W-last cancel out and leave the credit as is.
        wc_sum   = {2'b00, w_cred_q} + WX_W'(aw_hs);
        wc_under = w_last_hs && (wc_sum == '0);
        wc_next  = wc_sum - WX_W'(w_last_hs);
        wc_over  = !wc_under && (wc_next > WR_LIMIT);
        w_cred_d = (wc_under || wc_over) ? w_cred_q : wc_next[WR_W-1:0];
    end

    // Occupancy counters; cleared by reset, even mid-burst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            w_cred_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every counter updates from
            // the same pre-edge values regardless of statement order.
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            w_cred_q <= w_cred_d;
        end
    end

    // Simulation-only protocol checks on counter underflow and saturation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!rd_under) else $error("axi_riscv_txn_limit: rd_cnt underflow (R last with no outstanding read)");
            assert (!rd_over)  else $error("axi_riscv_txn_limit: rd_cnt saturation beyond %0d", MAX_READ_TXNS);
            assert (!wr_under) else $error("axi_riscv_txn_limit: wr_cnt underflow (B with no outstanding write)");
            assert (!wr_over)  else $error("axi_riscv_txn_limit: wr_cnt saturation beyond %0d", MAX_WRITE_TXNS);
            assert (!wc_under) else $error("axi_riscv_txn_limit: w_cred underflow (W last with no forwarded AW)");
            assert (!wc_over)  else $error("axi_riscv_txn_limit: w_cred saturation beyond %0d", MAX_WRITE_TXNS);
        end
    end

`ifdef AXI_RISCV_TXN_LIMIT_STATS_EN
    logic [31:0] stall_aw_q;
    logic [31:0] stall_ar_q;
    logic [31:0] stall_w_q;

    // Saturating stall-cycle counters: upstream valid present but gated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_aw_q <= '0;
            stall_ar_q <= '0;
            stall_w_q  <= '0;
        end else begin
            if (slv_aw_valid_i && !aw_ok && (stall_aw_q != '1)) begin
                stall_aw_q <= stall_aw_q + 32'd1;
            end
            if (slv_ar_valid_i && !ar_ok && (stall_ar_q != '1)) begin
                stall_ar_q <= stall_ar_q + 32'd1;
            end
            if (slv_w_valid_i && !w_ok && (stall_w_q != '1)) begin
                stall_w_q <= stall_w_q + 32'd1;
            end
        end
    end

    assign stall_aw_o = stall_aw_q;
    assign stall_ar_o = stall_ar_q;
    assign stall_w_o  = stall_w_q;
`endif

endmodule

// File: tb/tb_axi_riscv_txn_limit.sv
// Testbench for axi_riscv_txn_limit (MAX_READ_TXNS=4, MAX_WRITE_TXNS=2).
// Stimulus pushes each expected downstream AR/AW/W handshake (payload and
// cycle) into a queue; a negedge monitor pops and compares whenever the DUT
// presents a handshake. Gate levels and counters are checked directly.
// Build with AXI_RISCV_TXN_LIMIT_STATS_EN to also exercise the stall counters.
module tb_axi_riscv_txn_limit;

    localparam int unsigned AWW   = 64;
    localparam int unsigned ARW   = 64;
    localparam int unsigned WW    = 73;
    localparam int unsigned RW    = 70;
    localparam int unsigned BW    = 8;
    localparam int unsigned MAX_R = 4;
    localparam int unsigned MAX_W = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;

    logic [AWW-1:0]  slv_aw_chan_i, mst_aw_chan_o;
    logic [5:0]      slv_aw_atop_i, mst_aw_atop_o;
    logic            slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
    logic [ARW-1:0]  slv_ar_chan_i, mst_ar_chan_o;
    logic            slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic [WW-1:0]   slv_w_chan_i, mst_w_chan_o;
    logic            slv_w_last_i, mst_w_last_o;
    logic            slv_w_valid_i, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i;
    logic [RW-1:0]   mst_r_chan_i, slv_r_chan_o;
    logic            mst_r_last_i, slv_r_last_o;
    logic            mst_r_valid_i, mst_r_ready_o, slv_r_valid_o, slv_r_ready_i;
    logic [BW-1:0]   mst_b_chan_i, slv_b_chan_o;
    logic            mst_b_valid_i, mst_b_ready_o, slv_b_valid_o, slv_b_ready_i;
`ifdef AXI_RISCV_TXN_LIMIT_STATS_EN
    logic [31:0]     stall_aw_o, stall_ar_o, stall_w_o;
`endif

    axi_riscv_txn_limit #(
        .AW_CHAN_W      (AWW),
        .AR_CHAN_W      (ARW),
        .W_CHAN_W       (WW),
        .R_CHAN_W       (RW),
        .B_CHAN_W       (BW),
        .MAX_READ_TXNS  (MAX_R),
        .MAX_WRITE_TXNS (MAX_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .slv_aw_chan_i  (slv_aw_chan_i),
        .slv_aw_atop_i  (slv_aw_atop_i),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .mst_aw_chan_o  (mst_aw_chan_o),
        .mst_aw_atop_o  (mst_aw_atop_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .slv_ar_chan_i  (slv_ar_chan_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .mst_ar_chan_o  (mst_ar_chan_o),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .slv_w_chan_i   (slv_w_chan_i),
        .slv_w_last_i   (slv_w_last_i),
        .slv_w_valid_i  (slv_w_valid_i),
        .slv_w_ready_o  (slv_w_ready_o),
        .mst_w_chan_o   (mst_w_chan_o),
        .mst_w_last_o   (mst_w_last_o),
        .mst_w_valid_o  (mst_w_valid_o),
        .mst_w_ready_i  (mst_w_ready_i),
        .mst_r_chan_i   (mst_r_chan_i),
        .mst_r_last_i   (mst_r_last_i),
        .mst_r_valid_i  (mst_r_valid_i),
        .mst_r_ready_o  (mst_r_ready_o),
        .slv_r_chan_o   (slv_r_chan_o),
        .slv_r_last_o   (slv_r_last_o),
        .slv_r_valid_o  (slv_r_valid_o),
        .slv_r_ready_i  (slv_r_ready_i),
        .mst_b_chan_i   (mst_b_chan_i),
        .mst_b_valid_i  (mst_b_valid_i),
        .mst_b_ready_o  (mst_b_ready_o),
        .slv_b_chan_o   (slv_b_chan_o),
        .slv_b_valid_o  (slv_b_valid_o),
        .slv_b_ready_i  (slv_b_ready_i)
`ifdef AXI_RISCV_TXN_LIMIT_STATS_EN
        ,
        .stall_aw_o     (stall_aw_o),
        .stall_ar_o     (stall_ar_o),
        .stall_w_o      (stall_w_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned cyc;
        logic [127:0] data;
    } exp_t;

    exp_t exp_ar[$];
    exp_t exp_aw[$];
    exp_t exp_w[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: handshake with no expected entry, expected none (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor: compare every downstream handshake against the queue.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (!rst_i) begin
            if (mst_ar_valid_o && mst_ar_ready_i) begin
                if (exp_ar.size() == 0) unexpected("ar_unexpected");
                else begin
                    e = exp_ar.pop_front();
                    check("ar_data",  128'(mst_ar_chan_o), e.data);
                    check("ar_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
            if (mst_aw_valid_o && mst_aw_ready_i) begin
                if (exp_aw.size() == 0) unexpected("aw_unexpected");
                else begin
                    e = exp_aw.pop_front();
                    check("aw_data",  128'({mst_aw_atop_o, mst_aw_chan_o}), e.data);
                    check("aw_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
            if (mst_w_valid_o && mst_w_ready_i) begin
                if (exp_w.size() == 0) unexpected("w_unexpected");
                else begin
                    e = exp_w.pop_front();
                    check("w_data",  128'({mst_w_last_o, mst_w_chan_o}), e.data);
                    check("w_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ar_issue(input int unsigned id);
        slv_ar_valid_i = 1'b1;
        slv_ar_chan_i  = ARW'(id);
        exp_ar.push_back('{cyc: cyc, data: 128'(ARW'(id))});
        tick();
        slv_ar_valid_i = 1'b0;
    endtask

    task automatic aw_issue(input int unsigned id);
        slv_aw_valid_i = 1'b1;
        slv_aw_chan_i  = AWW'(id);
        slv_aw_atop_i  = 6'd0;
        exp_aw.push_back('{cyc: cyc, data: 128'({6'd0, AWW'(id)})});
        tick();
        slv_aw_valid_i = 1'b0;
    endtask

    task automatic w_beat(input int unsigned id, input logic last);
        slv_w_valid_i = 1'b1;
        slv_w_chan_i  = WW'(id);
        slv_w_last_i  = last;
        exp_w.push_back('{cyc: cyc, data: 128'({last, WW'(id)})});
        tick();
        slv_w_valid_i = 1'b0;
        slv_w_last_i  = 1'b0;
    endtask

    task automatic r_last();
        mst_r_valid_i = 1'b1;
        mst_r_last_i  = 1'b1;
        tick();
        mst_r_valid_i = 1'b0;
        mst_r_last_i  = 1'b0;
    endtask

    task automatic b_resp();
        mst_b_valid_i = 1'b1;
        tick();
        mst_b_valid_i = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int unsigned rd, input int unsigned wr, input int unsigned wc);
        check({tag, "_rd_cnt"}, 128'(dut.rd_cnt_q), 128'(rd));
        check({tag, "_wr_cnt"}, 128'(dut.wr_cnt_q), 128'(wr));
        check({tag, "_w_cred"}, 128'(dut.w_cred_q), 128'(wc));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i          = 1'b1;
        slv_aw_chan_i  = '0;
        slv_aw_atop_i  = '0;
        slv_aw_valid_i = 1'b0;
        mst_aw_ready_i = 1'b1;
        slv_ar_chan_i  = '0;
        slv_ar_valid_i = 1'b0;
        mst_ar_ready_i = 1'b1;
        slv_w_chan_i   = '0;
        slv_w_last_i   = 1'b0;
        slv_w_valid_i  = 1'b0;
        mst_w_ready_i  = 1'b1;
        mst_r_chan_i   = RW'(70'h2A_DEAD_BEEF);
        mst_r_last_i   = 1'b0;
        mst_r_valid_i  = 1'b0;
        slv_r_ready_i  = 1'b1;
        mst_b_chan_i   = 8'h5A;
        mst_b_valid_i  = 1'b0;
        slv_b_ready_i  = 1'b1;

        // Reset state: counters clear, gates follow counts of 0.
        repeat (3) tick();
        check_cnts("reset", 0, 0, 0);
        check("reset_ar_ready", 128'(slv_ar_ready_o), 128'd1);
        check("reset_aw_ready", 128'(slv_aw_ready_o), 128'd1);
        check("reset_w_ready",  128'(slv_w_ready_o),  128'd0);
        rst_i = 1'b0;
        tick();

        // Read limit: four ARs pass, the fifth waits for an R last and is
        // accepted only in the following cycle.
        for (int i = 0; i < 4; i++) ar_issue(100 + i);
        slv_ar_valid_i = 1'b1;
        slv_ar_chan_i  = ARW'(104);
        for (int i = 0; i < 3; i++) begin
            #3;
            check("rd_full_ar_ready", 128'(slv_ar_ready_o), 128'd0);
            check("rd_full_ar_valid", 128'(mst_ar_valid_o), 128'd0);
            tick();
        end
        check("rd_full_cnt", 128'(dut.rd_cnt_q), 128'd4);
        mst_r_valid_i = 1'b1;
        mst_r_last_i  = 1'b1;
        #3;
        check("r_last_no_bypass", 128'(slv_ar_ready_o), 128'd0);
        check("r_pass_valid",     128'(slv_r_valid_o),  128'd1);
        check("r_pass_last",      128'(slv_r_last_o),   128'd1);
        check("r_pass_chan",      128'(slv_r_chan_o),   128'(RW'(70'h2A_DEAD_BEEF)));
        check("r_pass_ready",     128'(mst_r_ready_o),  128'd1);
        tick();
        mst_r_valid_i = 1'b0;
        mst_r_last_i  = 1'b0;
        exp_ar.push_back('{cyc: cyc, data: 128'(ARW'(104))});
        #3;
        check("ar5_ready_after_free", 128'(slv_ar_ready_o), 128'd1);
        tick();
        // Sixth AR: full again, needs another completion.
        slv_ar_chan_i = ARW'(105);
        #3;
        check("ar6_blocked", 128'(slv_ar_ready_o), 128'd0);
        mst_r_valid_i = 1'b1;
        mst_r_last_i  = 1'b1;
        tick();
        mst_r_valid_i = 1'b0;
        mst_r_last_i  = 1'b0;
        exp_ar.push_back('{cyc: cyc, data: 128'(ARW'(105))});
        tick();
        slv_ar_valid_i = 1'b0;
        repeat (4) r_last();
        check_cnts("rd_drain", 0, 0, 0);

        // W ahead of AW: held until the AW handshake, then a 4-beat burst.
        slv_w_valid_i = 1'b1;
        slv_w_chan_i  = WW'(16'h1000);
        slv_w_last_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("w_early_valid", 128'(mst_w_valid_o), 128'd0);
            check("w_early_ready", 128'(slv_w_ready_o), 128'd0);
            tick();
        end
        slv_aw_valid_i = 1'b1;
        slv_aw_chan_i  = AWW'(200);
        slv_aw_atop_i  = 6'd0;
        exp_aw.push_back('{cyc: cyc, data: 128'({6'd0, AWW'(200)})});
        #3;
        check("w_held_in_aw_cycle", 128'(mst_w_valid_o), 128'd0);
        tick();
        slv_aw_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) w_beat(32'h1000 + b, b == 3);
        check_cnts("w_burst_done", 0, 1, 0);
        slv_w_valid_i = 1'b1;
        slv_w_chan_i  = WW'(16'h2000);
        #3;
        check("w_no_cred_after_last", 128'(mst_w_valid_o), 128'd0);
        slv_w_valid_i = 1'b0;
        mst_b_valid_i = 1'b1;
        #1;
        check("b_pass_valid", 128'(slv_b_valid_o), 128'd1);
        check("b_pass_chan",  128'(slv_b_chan_o),  128'h5A);
        check("b_pass_ready", 128'(mst_b_ready_o), 128'd1);
        tick();
        mst_b_valid_i = 1'b0;
        check("wr_after_b", 128'(dut.wr_cnt_q), 128'd0);

        // Last read slot contested: AR wins over the ATOP AW.
        for (int i = 0; i < 3; i++) ar_issue(300 + i);
        slv_ar_valid_i = 1'b1;
        slv_ar_chan_i  = ARW'(303);
        exp_ar.push_back('{cyc: cyc, data: 128'(ARW'(303))});
        slv_aw_valid_i = 1'b1;
        slv_aw_chan_i  = AWW'(400);
        slv_aw_atop_i  = 6'b100000;
        #3;
        check("prio_ar_ready", 128'(slv_ar_ready_o), 128'd1);
        check("prio_aw_ready", 128'(slv_aw_ready_o), 128'd0);
        check("prio_aw_valid", 128'(mst_aw_valid_o), 128'd0);
        tick();
        slv_ar_valid_i = 1'b0;
        mst_r_valid_i  = 1'b1;
        mst_r_last_i   = 1'b1;
        #3;
        check("atop_blocked_rd_full", 128'(slv_aw_ready_o), 128'd0);
        tick();
        mst_r_valid_i = 1'b0;
        mst_r_last_i  = 1'b0;
        exp_aw.push_back('{cyc: cyc, data: 128'({6'b100000, AWW'(400)})});
        #3;
        check("atop_accepted", 128'(slv_aw_ready_o), 128'd1);
        tick();
        slv_aw_valid_i = 1'b0;
        slv_aw_atop_i  = 6'd0;
        check_cnts("atop_done", 4, 1, 1);
        w_beat(32'h3000, 1'b1);
        b_resp();
        repeat (4) r_last();
        check_cnts("atop_drain", 0, 0, 0);

        // Write full boundary: B and new AW in the same cycle.
        aw_issue(500);
        aw_issue(501);
        w_beat(32'h5000, 1'b1);
        w_beat(32'h5001, 1'b1);
        check_cnts("wr_full", 0, 2, 0);
        slv_aw_valid_i = 1'b1;
        slv_aw_chan_i  = AWW'(502);
        mst_b_valid_i  = 1'b1;
        #3;
        check("wr_full_aw_ready", 128'(slv_aw_ready_o), 128'd0);
        check("wr_full_aw_valid", 128'(mst_aw_valid_o), 128'd0);
        tick();
        mst_b_valid_i = 1'b0;
        exp_aw.push_back('{cyc: cyc, data: 128'({6'd0, AWW'(502)})});
        #3;
        check("wr_freed_aw_ready", 128'(slv_aw_ready_o), 128'd1);
        tick();
        slv_aw_valid_i = 1'b0;
        check("wr_refilled", 128'(dut.wr_cnt_q), 128'd2);
        w_beat(32'h5002, 1'b1);
        b_resp();
        b_resp();
        check_cnts("wr_drain", 0, 0, 0);

        // Reset with transactions in flight.
        for (int i = 0; i < 3; i++) ar_issue(600 + i);
        aw_issue(700);
        check_cnts("pre_reset", 3, 1, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_cnts("mid_reset", 0, 0, 0);
        slv_ar_valid_i = 1'b1;
        slv_ar_chan_i  = ARW'(603);
        exp_ar.push_back('{cyc: cyc, data: 128'(ARW'(603))});
        #3;
        check("post_reset_ar_ready", 128'(slv_ar_ready_o), 128'd1);
        tick();
        slv_ar_valid_i = 1'b0;
        check("post_reset_rd_cnt", 128'(dut.rd_cnt_q), 128'd1);

`ifdef AXI_RISCV_TXN_LIMIT_STATS_EN
        // AR held for ten cycles against a full read limit.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) ar_issue(800 + i);
        slv_ar_valid_i = 1'b1;
        slv_ar_chan_i  = ARW'(900);
        repeat (10) tick();
        slv_ar_valid_i = 1'b0;
        check("stall_ar", 128'(stall_ar_o), 128'd10);
        check("stall_aw", 128'(stall_aw_o), 128'd0);
        check("stall_w",  128'(stall_w_o),  128'd0);
`endif

        repeat (2) tick();
        check("ar_queue_empty", 128'(exp_ar.size()), 128'd0);
        check("aw_queue_empty", 128'(exp_aw.size()), 128'd0);
        check("w_queue_empty",  128'(exp_w.size()),  128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
